// File: rtl/rf_ctrl_pkg.sv
// Shared types and default geometry for the register-file controller.
package rf_ctrl_pkg;

    localparam int RF_DEPTH = 32;
    localparam int RF_AW    = 5;
    localparam int RF_DW    = 8;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        DBG   = 2'd2,
        ACK   = 2'd3
    } state_t;

endpackage

// File: rtl/rf_controller_if.sv
// Bundle of the controller's CPU, debug, clear and register-file signals,
// used by the parent to wire the controller beside the register file.
interface rf_controller_if #(
    parameter int AW = rf_ctrl_pkg::RF_AW,
    parameter int DW = rf_ctrl_pkg::RF_DW
) ();

    logic          cpu_wr;
    logic [AW-1:0] cpu_addr_wr;
    logic [DW-1:0] cpu_din;
    logic [AW-1:0] cpu_addrx;
    logic [AW-1:0] cpu_addry;
    logic          cpu_stall;

    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_ack;
    logic [DW-1:0] dbg_rdata;

    logic          clr_start;
    logic          clr_busy;

    logic [AW-1:0] rf_addrx;
    logic [AW-1:0] rf_addry;
    logic [AW-1:0] rf_addr_wr;
    logic          rf_wr;
    logic [DW-1:0] rf_din;
    logic [DW-1:0] rf_dx_out;

    // Requester / register-file side.
    modport master (
        output cpu_wr, cpu_addr_wr, cpu_din, cpu_addrx, cpu_addry,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, clr_start, rf_dx_out,
        input  cpu_stall, dbg_ack, dbg_rdata, clr_busy,
        input  rf_addrx, rf_addry, rf_addr_wr, rf_wr, rf_din
    );

    // Controller side.
    modport slave (
        input  cpu_wr, cpu_addr_wr, cpu_din, cpu_addrx, cpu_addry,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, clr_start, rf_dx_out,
        output cpu_stall, dbg_ack, dbg_rdata, clr_busy,
        output rf_addrx, rf_addry, rf_addr_wr, rf_wr, rf_din
    );

endinterface

// File: rtl/rf_controller.sv
// Arbitrates register-file access between the CPU, a 4-phase debug port and
// a whole-file clear sequence that also runs out of reset.
module rf_controller
    import rf_ctrl_pkg::*;
#(
    parameter int DEPTH = RF_DEPTH,
    parameter int AW    = RF_AW,
    parameter int DW    = RF_DW
) (
    input  logic          RF_CLK,
    input  logic          RF_RST_N,

    input  logic          CPU_WR,
    input  logic [AW-1:0] CPU_ADDR_WR,
    input  logic [DW-1:0] CPU_DIN,
    input  logic [AW-1:0] CPU_ADDRX,
    input  logic [AW-1:0] CPU_ADDRY,
    output logic          CPU_STALL,

    input  logic          DBG_REQ,
    input  logic          DBG_WE,
    input  logic [AW-1:0] DBG_ADDR,
    input  logic [DW-1:0] DBG_WDATA,
    output logic          DBG_ACK,
    output logic [DW-1:0] DBG_RDATA,

    input  logic          CLR_START,
    output logic          CLR_BUSY,

    output logic [AW-1:0] RF_ADDRX,
    output logic [AW-1:0] RF_ADDRY,
    output logic [AW-1:0] RF_ADDR_WR,
    output logic          RF_WR,
    output logic [DW-1:0] RF_DIN,
    input  logic [DW-1:0] RF_DX_OUT
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] clr_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge RF_CLK or negedge RF_RST_N) begin
        if (!RF_RST_N) begin
            state     <= CLEAR;
            clr_cnt   <= '0;
            DBG_RDATA <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR) begin
                clr_cnt <= (clr_cnt == LAST_ADDR) ? '0 : clr_cnt + 1'b1;
            end
            // Captured at the closing edge of DBG: old contents before the write lands.
            if (state == DBG) begin
                DBG_RDATA <= RF_DX_OUT;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves one unassigned and infers a latch.
    always_comb begin
        state_next = state;
        RF_ADDRX   = CPU_ADDRX;
        RF_ADDR_WR = CPU_ADDR_WR;
        RF_DIN     = CPU_DIN;
        RF_WR      = 1'b0;
        CLR_BUSY   = 1'b0;
        DBG_ACK    = 1'b0;

        case (state)
            CLEAR: begin
                RF_WR      = 1'b1;
                RF_ADDR_WR = clr_cnt;
                RF_DIN     = '0;
                CLR_BUSY   = 1'b1;
                if (clr_cnt == LAST_ADDR) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                RF_WR = CPU_WR;
                if (CLR_START) begin
                    state_next = CLEAR;
                end else if (DBG_REQ) begin
                    state_next = DBG;
                end
            end
            DBG: begin
                RF_ADDRX   = DBG_ADDR;
                RF_ADDR_WR = DBG_ADDR;
                RF_DIN     = DBG_WDATA;
                RF_WR      = DBG_WE;
                state_next = ACK;
            end
            ACK: begin
                DBG_ACK = 1'b1;
                if (!DBG_REQ) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    assign CPU_STALL = (state != IDLE);
    assign RF_ADDRY  = CPU_ADDRY;

endmodule

// File: tb/tb_rf_controller.sv
// Bench for rf_controller: directed scenarios plus randomized CPU/debug traffic
// checked against a register-contents model kept in plain arrays.
module tb_rf_controller;

    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int DW    = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rf_controller_if #(.AW(AW), .DW(DW)) bus ();

    rf_controller #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .RF_CLK      (clk),
        .RF_RST_N    (rst_n),
        .CPU_WR      (bus.cpu_wr),
        .CPU_ADDR_WR (bus.cpu_addr_wr),
        .CPU_DIN     (bus.cpu_din),
        .CPU_ADDRX   (bus.cpu_addrx),
        .CPU_ADDRY   (bus.cpu_addry),
        .CPU_STALL   (bus.cpu_stall),
        .DBG_REQ     (bus.dbg_req),
        .DBG_WE      (bus.dbg_we),
        .DBG_ADDR    (bus.dbg_addr),
        .DBG_WDATA   (bus.dbg_wdata),
        .DBG_ACK     (bus.dbg_ack),
        .DBG_RDATA   (bus.dbg_rdata),
        .CLR_START   (bus.clr_start),
        .CLR_BUSY    (bus.clr_busy),
        .RF_ADDRX    (bus.rf_addrx),
        .RF_ADDRY    (bus.rf_addry),
        .RF_ADDR_WR  (bus.rf_addr_wr),
        .RF_WR       (bus.rf_wr),
        .RF_DIN      (bus.rf_din),
        .RF_DX_OUT   (bus.rf_dx_out)
    );

    // Register file owned by the parent.
    logic [DW-1:0] rf_mem [DEPTH];
    always @(posedge clk) if (bus.rf_wr === 1'b1) rf_mem[bus.rf_addr_wr] <= bus.rf_din;
    assign bus.rf_dx_out = rf_mem[bus.rf_addrx];

    // Reference model: what each entry should hold and what DBG_RDATA should show.
    logic [DW-1:0] model_regs [DEPTH];
    logic [DW-1:0] model_rdata;

    int n_cmp = 0;
    int n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cpu_wr      = 1'b0;
        bus.cpu_addr_wr = AW'($urandom_range(0, DEPTH - 1));
        bus.cpu_din     = DW'($urandom);
        bus.cpu_addrx   = AW'($urandom_range(0, DEPTH - 1));
        bus.cpu_addry   = AW'($urandom_range(0, DEPTH - 1));
        bus.dbg_req     = 1'b0;
        bus.dbg_we      = 1'b0;
        bus.dbg_addr    = AW'($urandom_range(0, DEPTH - 1));
        bus.dbg_wdata   = DW'($urandom);
        bus.clr_start   = 1'b0;
    endtask

    task automatic model_cleared();
        for (int i = 0; i < DEPTH; i++) model_regs[i] = '0;
    endtask

    // Expects to be called in the first CLEAR cycle (counter at 0).
    task automatic expect_clear(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            bus.cpu_wr      = 1'b1;
            bus.cpu_addr_wr = AW'($urandom_range(0, DEPTH - 1));
            bus.cpu_din     = DW'($urandom_range(1, 255));
            bus.cpu_addry   = AW'($urandom_range(0, DEPTH - 1));
            bus.clr_start   = 1'($urandom);
            #1;
            n_cmp++;
            if (bus.rf_wr !== 1'b1 || bus.rf_addr_wr !== AW'(i) || bus.rf_din !== '0 ||
                bus.clr_busy !== 1'b1 || bus.cpu_stall !== 1'b1 || bus.dbg_ack !== 1'b0 ||
                bus.rf_addry !== bus.cpu_addry) begin
                n_err++;
                $display("FAIL %s cycle %0d: wr=%b addr=%0d din=%h busy=%b stall=%b ack=%b, required wr=1 addr=%0d din=00 busy=1 stall=1 ack=0",
                         tag, i, bus.rf_wr, bus.rf_addr_wr, bus.rf_din, bus.clr_busy, bus.cpu_stall, bus.dbg_ack, i);
            end
            tick();
        end
        bus.cpu_wr    = 1'b0;
        bus.clr_start = 1'b0;
        model_cleared();
        #1;
        n_cmp++;
        if (bus.clr_busy !== 1'b0 || bus.cpu_stall !== 1'b0) begin
            n_err++;
            $display("FAIL %s_end: busy=%b stall=%b, required busy=0 stall=0", tag, bus.clr_busy, bus.cpu_stall);
        end
    endtask

    task automatic cpu_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input string tag);
        bus.cpu_wr      = 1'b1;
        bus.cpu_addr_wr = addr;
        bus.cpu_din     = data;
        #1;
        n_cmp++;
        if (bus.rf_wr !== 1'b1 || bus.rf_addr_wr !== addr || bus.rf_din !== data || bus.cpu_stall !== 1'b0) begin
            n_err++;
            $display("FAIL %s: wr=%b addr=%0d din=%h stall=%b, required wr=1 addr=%0d din=%h stall=0",
                     tag, bus.rf_wr, bus.rf_addr_wr, bus.rf_din, bus.cpu_stall, addr, data);
        end
        tick();
        model_regs[addr] = data;
        bus.cpu_wr = 1'b0;
    endtask

    task automatic cpu_read_check(input logic [AW-1:0] addr, input string tag);
        bus.cpu_addrx = addr;
        bus.cpu_addry = AW'($urandom_range(0, DEPTH - 1));
        #1;
        n_cmp++;
        if (bus.rf_addrx !== addr || bus.rf_dx_out !== model_regs[addr] || bus.rf_wr !== 1'b0 ||
            bus.rf_addry !== bus.cpu_addry || bus.dbg_rdata !== model_rdata) begin
            n_err++;
            $display("FAIL %s: addrx=%0d data=%h wr=%b rdata=%h, required addrx=%0d data=%h wr=0 rdata=%h",
                     tag, bus.rf_addrx, bus.rf_dx_out, bus.rf_wr, bus.dbg_rdata, addr, model_regs[addr], model_rdata);
        end
    endtask

    // Full 4-phase debug access from IDLE; request is held for `hold` ACK cycles.
    task automatic dbg_access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                              input int hold, input string tag);
        logic [DW-1:0] old_val;
        old_val       = model_regs[addr];
        bus.cpu_wr    = 1'b0;
        bus.dbg_req   = 1'b1;
        bus.dbg_we    = we;
        bus.dbg_addr  = addr;
        bus.dbg_wdata = wdata;
        #1;
        n_cmp++;
        if (bus.cpu_stall !== 1'b0 || bus.dbg_ack !== 1'b0) begin
            n_err++;
            $display("FAIL %s_req: stall=%b ack=%b, required 0 0", tag, bus.cpu_stall, bus.dbg_ack);
        end
        tick();
        // CPU and clear requests during the access must have no effect.
        bus.cpu_wr      = 1'b1;
        bus.cpu_addr_wr = AW'($urandom_range(0, DEPTH - 1));
        bus.cpu_din     = DW'($urandom);
        bus.clr_start   = 1'b1;
        #1;
        n_cmp++;
        if (bus.cpu_stall !== 1'b1 || bus.dbg_ack !== 1'b0 || bus.rf_wr !== we || bus.rf_addr_wr !== addr ||
            bus.rf_din !== wdata || bus.rf_addrx !== addr || bus.dbg_rdata !== model_rdata) begin
            n_err++;
            $display("FAIL %s_dbg: stall=%b ack=%b wr=%b addr=%0d din=%h addrx=%0d rdata=%h, required 1 0 %b %0d %h %0d %h",
                     tag, bus.cpu_stall, bus.dbg_ack, bus.rf_wr, bus.rf_addr_wr, bus.rf_din, bus.rf_addrx,
                     bus.dbg_rdata, we, addr, wdata, addr, model_rdata);
        end
        tick();
        model_rdata = old_val;
        if (we) model_regs[addr] = wdata;
        for (int h = 0; h <= hold; h++) begin
            if (h == hold) bus.dbg_req = 1'b0;
            #1;
            n_cmp++;
            if (bus.dbg_ack !== 1'b1 || bus.cpu_stall !== 1'b1 || bus.rf_wr !== 1'b0 || bus.dbg_rdata !== model_rdata) begin
                n_err++;
                $display("FAIL %s_ack%0d: ack=%b stall=%b wr=%b rdata=%h, required 1 1 0 %h",
                         tag, h, bus.dbg_ack, bus.cpu_stall, bus.rf_wr, bus.dbg_rdata, model_rdata);
            end
            tick();
        end
        idle_inputs();
        #1;
        n_cmp++;
        if (bus.dbg_ack !== 1'b0 || bus.cpu_stall !== 1'b0 || bus.dbg_rdata !== model_rdata) begin
            n_err++;
            $display("FAIL %s_done: ack=%b stall=%b rdata=%h, required 0 0 %h",
                     tag, bus.dbg_ack, bus.cpu_stall, bus.dbg_rdata, model_rdata);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.clr_busy !== 1'b1 || bus.cpu_stall !== 1'b1 || bus.dbg_ack !== 1'b0 || bus.rf_wr !== 1'b1 ||
            bus.rf_addr_wr !== '0 || bus.rf_din !== '0 || bus.dbg_rdata !== '0) begin
            n_err++;
            $display("FAIL reset_state: busy=%b stall=%b ack=%b wr=%b addr=%0d din=%h rdata=%h, required 1 1 0 1 0 00 00",
                     bus.clr_busy, bus.cpu_stall, bus.dbg_ack, bus.rf_wr, bus.rf_addr_wr, bus.rf_din, bus.dbg_rdata);
        end
        tick();
        tick();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        model_rdata = '0;
        expect_clear("reset_clear");
    endtask

    task automatic test_cpu_passthrough();
        tick();
        cpu_write(5'd5, 8'hA5, "cpu_pass");
        cpu_read_check(5'd5, "cpu_pass_read");
        n_cmp++;
        if (bus.rf_dx_out !== 8'hA5) begin
            n_err++;
            $display("FAIL cpu_pass_value: got %h, required a5", bus.rf_dx_out);
        end
    endtask

    task automatic test_dbg_write();
        tick();
        cpu_write(5'd3, 8'h11, "dbg_write_setup");
        dbg_access(1'b1, 5'd3, 8'h7E, 3, "dbg_write");
        n_cmp++;
        if (bus.dbg_rdata !== 8'h11) begin
            n_err++;
            $display("FAIL dbg_write_rdata: got %h, required 11", bus.dbg_rdata);
        end
        cpu_read_check(5'd3, "dbg_write_read");
        n_cmp++;
        if (bus.rf_dx_out !== 8'h7E) begin
            n_err++;
            $display("FAIL dbg_write_value: got %h, required 7e", bus.rf_dx_out);
        end
    endtask

    task automatic test_collision();
        tick();
        cpu_write(5'd7, 8'h5A, "collision_setup");
        bus.clr_start = 1'b1;
        bus.dbg_req   = 1'b1;
        bus.dbg_we    = 1'b0;
        bus.dbg_addr  = 5'd7;
        #1;
        tick();
        expect_clear("collision_clear");
        tick();
        n_cmp++;
        if (bus.cpu_stall !== 1'b1 || bus.rf_wr !== 1'b0 || bus.dbg_ack !== 1'b0) begin
            n_err++;
            $display("FAIL collision_dbg: stall=%b wr=%b ack=%b, required 1 0 0", bus.cpu_stall, bus.rf_wr, bus.dbg_ack);
        end
        tick();
        model_rdata = 8'h00;
        n_cmp++;
        if (bus.dbg_ack !== 1'b1 || bus.dbg_rdata !== 8'h00) begin
            n_err++;
            $display("FAIL collision_ack: ack=%b rdata=%h, required 1 00", bus.dbg_ack, bus.dbg_rdata);
        end
        bus.dbg_req = 1'b0;
        tick();
        idle_inputs();
    endtask

    task automatic test_cpu_plus_dbg();
        tick();
        bus.cpu_wr      = 1'b1;
        bus.cpu_addr_wr = 5'd2;
        bus.cpu_din     = 8'h33;
        bus.dbg_req     = 1'b1;
        bus.dbg_we      = 1'b0;
        bus.dbg_addr    = 5'd2;
        #1;
        n_cmp++;
        if (bus.rf_wr !== 1'b1 || bus.rf_addr_wr !== 5'd2 || bus.rf_din !== 8'h33 || bus.cpu_stall !== 1'b0) begin
            n_err++;
            $display("FAIL cpu_dbg_write: wr=%b addr=%0d din=%h stall=%b, required 1 2 33 0",
                     bus.rf_wr, bus.rf_addr_wr, bus.rf_din, bus.cpu_stall);
        end
        tick();
        model_regs[2] = 8'h33;
        bus.cpu_din = 8'hEE;
        #1;
        n_cmp++;
        if (bus.rf_wr !== 1'b0 || bus.cpu_stall !== 1'b1) begin
            n_err++;
            $display("FAIL cpu_dbg_dbgcycle: wr=%b stall=%b, required 0 1", bus.rf_wr, bus.cpu_stall);
        end
        tick();
        model_rdata = 8'h33;
        n_cmp++;
        if (bus.dbg_ack !== 1'b1 || bus.dbg_rdata !== 8'h33) begin
            n_err++;
            $display("FAIL cpu_dbg_ack: ack=%b rdata=%h, required 1 33", bus.dbg_ack, bus.dbg_rdata);
        end
        bus.dbg_req = 1'b0;
        tick();
        idle_inputs();
        cpu_read_check(5'd2, "cpu_dbg_read");
    endtask

    task automatic test_mid_clear_reset();
        tick();
        bus.clr_start = 1'b1;
        #1;
        tick();
        bus.clr_start = 1'b0;
        for (int i = 0; i < 17; i++) tick();
        n_cmp++;
        if (bus.rf_addr_wr !== 5'd17 || bus.clr_busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_clear_pre: addr=%0d busy=%b, required 17 1", bus.rf_addr_wr, bus.clr_busy);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.rf_addr_wr !== '0 || bus.clr_busy !== 1'b1 || bus.rf_wr !== 1'b1) begin
            n_err++;
            $display("FAIL mid_clear_reset: addr=%0d busy=%b wr=%b, required 0 1 1", bus.rf_addr_wr, bus.clr_busy, bus.rf_wr);
        end
        rst_n = 1'b1;
        model_rdata = '0;
        expect_clear("mid_clear_restart");
    endtask

    task automatic test_dbg_abort();
        tick();
        cpu_write(5'd9, 8'hC3, "abort_setup");
        dbg_access(1'b0, 5'd9, 8'h00, 0, "abort_prime");
        bus.dbg_req   = 1'b1;
        bus.dbg_we    = 1'b1;
        bus.dbg_addr  = 5'd9;
        bus.dbg_wdata = 8'h44;
        #1;
        tick();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.dbg_ack !== 1'b0 || bus.dbg_rdata !== '0 || bus.clr_busy !== 1'b1 || bus.cpu_stall !== 1'b1) begin
            n_err++;
            $display("FAIL dbg_abort: ack=%b rdata=%h busy=%b stall=%b, required 0 00 1 1",
                     bus.dbg_ack, bus.dbg_rdata, bus.clr_busy, bus.cpu_stall);
        end
        bus.dbg_req = 1'b0;
        rst_n = 1'b1;
        model_rdata = '0;
        expect_clear("dbg_abort_clear");
        cpu_read_check(5'd9, "dbg_abort_read");
    endtask

    task automatic test_random();
        for (int n = 0; n < 150; n++) begin
            tick();
            case ($urandom_range(0, 2))
                0: cpu_write(AW'($urandom_range(0, DEPTH - 1)), DW'($urandom), "rand_cpu_write");
                1: cpu_read_check(AW'($urandom_range(0, DEPTH - 1)), "rand_cpu_read");
                default: dbg_access(1'($urandom), AW'($urandom_range(0, DEPTH - 1)), DW'($urandom),
                                    $urandom_range(0, 2), "rand_dbg");
            endcase
        end
        for (int a = 0; a < DEPTH; a++) begin
            cpu_read_check(AW'(a), "final_sweep");
            tick();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cpu_passthrough();
        test_dbg_write();
        test_collision();
        test_cpu_plus_dbg();
        test_mid_clear_reset();
        test_dbg_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
